// File: rtl/npc_pkg.sv
// -----------------------------------------------------------------------------
// npc_pkg
//   Shared types for the npc pipeline registers.
//   - dstage_t / xstage_t / mstage_t / wstage_t: packed payloads carried by
//     pipe_stage_buf between decode, execute, memory and writeback.
//     npc instantiates pipe_stage_buf with WIDTH=$bits(<stage>_t).
//   - ptr_inc: circular pointer increment for a queue of any depth, including
//     depths that are not powers of two.
// -----------------------------------------------------------------------------
package npc_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } dstage_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [3:0]  alu_op;
    } xstage_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        mem_we;
        logic        mem_re;
    } mstage_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
        logic        rd_we;
    } wstage_t;

    // Next slot of a circular queue: wraps to 0 after the last entry.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pipe_stage_ram.sv
// -----------------------------------------------------------------------------
// pipe_stage_ram
//   DEPTH x WIDTH storage array for pipe_stage_buf.
//   Ports:
//     i_clk    clock
//     i_rst    synchronous clear of every entry to RESET_DATA (active-high)
//     i_we     write enable
//     i_waddr  write address
//     i_wdata  write data
//     i_raddr  read address (asynchronous read)
//     o_rdata  read data
// -----------------------------------------------------------------------------
module pipe_stage_ram #(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 2,
    parameter int               ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_DATA;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//   Elastic pipeline-stage buffer: DEPTH-entry circular queue of opaque
//   WIDTH-bit payloads with synchronous flush, optional fall-through and an
//   occupancy output.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     flush      synchronous squash of every held entry
//     s_valid / s_ready / s_data   upstream side
//     m_valid / m_ready / m_data   downstream side
//     count      entries currently held
//
//   Handshake: a beat transfers on a side when valid & ready are both high at
//   posedge. s_ready comes from registered occupancy only (never from m_ready),
//   so a full buffer refuses a push even if it pops in the same cycle. While
//   m_valid & ~m_ready the stored output holds; the fall-through path simply
//   mirrors upstream and carries no such guarantee.
// -----------------------------------------------------------------------------
module pipe_stage_buf
    import npc_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 2,
    parameter int               FALLTHROUGH = 0,
    parameter logic [WIDTH-1:0] RESET_DATA  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_ft_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass;
    logic             w_wr;
    logic             w_rd;
    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [WIDTH-1:0] w_rdata;

    assign w_empty    = (r_count == '0);
    // Fall-through mode is only active while nothing is stored.
    assign w_ft_empty = (FALLTHROUGH != 0) && w_empty;

    assign s_ready = (r_count < DEPTH_C) & ~rst;
    assign m_valid = rst ? 1'b0       : (w_ft_empty ? s_valid : ~w_empty);
    assign m_data  = rst ? RESET_DATA : (w_ft_empty ? s_data  : w_rdata);

    assign w_push = s_valid & s_ready;
    assign w_pop  = m_valid & m_ready;

    // An item pushed into an empty fall-through buffer and taken downstream in
    // the same cycle never touches storage.
    assign w_bypass = w_ft_empty & w_push & m_ready;
    assign w_wr     = w_push & ~w_bypass & ~flush;
    // A pop while fall-through-empty is always the bypass; nothing to dequeue.
    assign w_rd     = w_pop & ~w_ft_empty;

    assign w_head_nxt = PTR_W'(ptr_inc(32'(r_head), DEPTH));
    assign w_tail_nxt = PTR_W'(ptr_inc(32'(r_tail), DEPTH));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_tail <= w_tail_nxt;
            end
            if (w_rd) begin
                r_head <= w_head_nxt;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;

    // Storage is cleared on flush as well, so m_data reads RESET_DATA afterwards.
    pipe_stage_ram #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W),
        .RESET_DATA (RESET_DATA)
    ) u_ram (
        .i_clk   (clk),
        .i_rst   (rst | flush),
        .i_we    (w_wr),
        .i_waddr (r_tail),
        .i_wdata (s_data),
        .i_raddr (r_head),
        .o_rdata (w_rdata)
    );

`ifndef SYNTHESIS
    int w_ptr_diff;

    always_comb begin
        w_ptr_diff = (int'(r_tail) + DEPTH - int'(r_head)) % DEPTH;
    end

    a_no_push_full : assert property (@(posedge clk) disable iff (rst)
        !(w_push && (r_count == DEPTH_C)));
    a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
        !(w_rd && w_empty));
    a_occupancy    : assert property (@(posedge clk) disable iff (rst)
        (r_count == DEPTH_C) ? (r_tail == r_head) : (int'(r_count) == w_ptr_diff));
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
//   Four buffers share one stimulus stream:
//     k=0 DEPTH=1 FT=0, k=1 DEPTH=2 FT=0, k=2 DEPTH=3 FT=0, k=3 DEPTH=2 FT=1.
//   Each is modelled as an ordered list (index 0 = oldest entry); every cycle
//   all outputs are compared against that list, and directed phases add
//   hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam logic [31:0] RD = 32'hC0DE_0000;
    localparam int          NI = 4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        s_valid;
    logic [31:0] s_data;
    logic        m_ready;

    logic        sr [NI];
    logic        mv [NI];
    logic [31:0] md [NI];
    logic [1:0]  cnt [NI];
    logic [0:0]  cnt_d1;

    assign cnt[0] = {1'b0, cnt_d1};

    pipe_stage_buf #(.WIDTH(32), .DEPTH(1), .FALLTHROUGH(0), .RESET_DATA(RD)) u_d1 (
        .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(sr[0]),
        .s_data(s_data), .m_valid(mv[0]), .m_ready(m_ready), .m_data(md[0]), .count(cnt_d1));
    pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .FALLTHROUGH(0), .RESET_DATA(RD)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(sr[1]),
        .s_data(s_data), .m_valid(mv[1]), .m_ready(m_ready), .m_data(md[1]), .count(cnt[1]));
    pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .FALLTHROUGH(0), .RESET_DATA(RD)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(sr[2]),
        .s_data(s_data), .m_valid(mv[2]), .m_ready(m_ready), .m_data(md[2]), .count(cnt[2]));
    pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .FALLTHROUGH(1), .RESET_DATA(RD)) u_ft (
        .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(sr[3]),
        .s_data(s_data), .m_valid(mv[3]), .m_ready(m_ready), .m_data(md[3]), .count(cnt[3]));

    // behavioural model: per buffer an ordered list of held items
    int          dep [NI];
    bit          ftv [NI];
    int          mcnt [NI];
    logic [31:0] mq [NI][8];
    bit          e_srdy [NI];
    bit          e_mval [NI];

    // scoreboard for the in-order stream through the DEPTH=2 buffer
    logic [31:0] exp_q[$];

    int n_cmp;
    int n_err;
    int n_x;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every DUT against the model at the negedge before the next edge.
    task automatic eval(input bit do_cmp);
        logic [31:0] mdat;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            mdat = RD;
            if (rst) begin
                e_srdy[k] = 1'b0;
                e_mval[k] = 1'b0;
            end else begin
                e_srdy[k] = (mcnt[k] < dep[k]);
                if (ftv[k] && mcnt[k] == 0) begin
                    e_mval[k] = s_valid;
                    mdat      = s_data;
                end else begin
                    e_mval[k] = (mcnt[k] != 0);
                    mdat      = mq[k][0];
                end
            end
            if (do_cmp) begin
                chk($sformatf("s_ready[%0d]", k), 32'(sr[k]), 32'(e_srdy[k]));
                chk($sformatf("m_valid[%0d]", k), 32'(mv[k]), 32'(e_mval[k]));
                chk($sformatf("count[%0d]", k), 32'(cnt[k]), 32'(mcnt[k]));
                if (rst || e_mval[k]) begin
                    chk($sformatf("m_data[%0d]", k), md[k], mdat);
                end
            end
        end
    endtask

    // Advance the model with the inputs seen at the posedge.
    task automatic tick();
        bit push;
        bit pop;
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            push = s_valid && e_srdy[k];
            pop  = e_mval[k] && m_ready;
            if (rst || flush) begin
                mcnt[k] = 0;
            end else if (ftv[k] && mcnt[k] == 0 && push && m_ready) begin
                // consumed straight through, nothing stored
            end else begin
                if (pop) begin
                    for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
                    mcnt[k]--;
                end
                if (push) begin
                    mq[k][mcnt[k]] = s_data;
                    mcnt[k]++;
                end
            end
        end
        #1;
    endtask

    task automatic step();
        eval(1'b1);
        tick();
    endtask

    task automatic drain();
        rst = 0; flush = 0; s_valid = 0; m_ready = 1;
        repeat (4) step();
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_x = 0;
        dep = '{1, 2, 3, 2};
        ftv = '{0, 0, 0, 1};
        for (int k = 0; k < NI; k++) mcnt[k] = 0;

        // 1. reset with upstream pushing
        rst = 1; flush = 0; s_valid = 1; s_data = 32'hDEAD; m_ready = 0;
        eval(1'b0);
        tick();
        eval(1'b1);
        chk("rst_s_ready", 32'(sr[1]), 0);
        chk("rst_m_valid", 32'(mv[1]), 0);
        chk("rst_count", 32'(cnt[1]), 0);
        chk("rst_ft_m_valid", 32'(mv[3]), 0);
        chk("rst_m_data", md[3], RD);
        tick();
        rst = 0;
        eval(1'b1);
        chk("post_rst_s_ready", 32'(sr[1]), 1);
        tick();
        drain();

        // 2. stream 1..8 through DEPTH=2; 6. DEPTH=1 transfers in 8 cycles
        s_valid = 1; m_ready = 1;
        for (int j = 0; j < 8; j++) begin
            s_data = 32'(j + 1);
            eval(1'b1);
            if (j == 0) chk("stream_latency", 32'(mv[1]), 0);
            if (mv[1]) begin
                if (exp_q.size() == 0) chk("stream_extra", md[1], 32'hFFFF_FFFF);
                else chk("stream_order", md[1], exp_q.pop_front());
            end
            if (j > 0) chk("stream_lit", md[1], 32'(j));
            chk("stream_cnt_le1", 32'(cnt[1] <= 2'd1), 1);
            if (mv[0] && m_ready) n_x++;
            exp_q.push_back(s_data);
            tick();
        end
        s_valid = 0;
        eval(1'b1);
        chk("stream_last_valid", 32'(mv[1]), 1);
        chk("stream_last", md[1], exp_q.pop_front());
        chk("stream_last_lit", md[1], 32'h8);
        tick();
        chk("d1_xfers", n_x, 4);
        drain();

        // 3. backpressure and wrap on DEPTH=3
        m_ready = 0; s_valid = 1;
        s_data = 32'hA; step();
        s_data = 32'hB; step();
        s_data = 32'hC; step();
        s_data = 32'hD;
        eval(1'b1);
        chk("bp_count", 32'(cnt[2]), 3);
        chk("bp_s_ready", 32'(sr[2]), 0);
        chk("bp_hold", md[2], 32'hA);
        tick();
        m_ready = 1;
        eval(1'b1);
        chk("bp_full_pop_s_ready", 32'(sr[2]), 0);
        chk("bp_out0", md[2], 32'hA);
        tick();
        eval(1'b1);
        chk("bp_out1", md[2], 32'hB);
        tick();
        s_valid = 0;
        eval(1'b1);
        chk("bp_out2", md[2], 32'hC);
        tick();
        eval(1'b1);
        chk("bp_out3", md[2], 32'hD);
        tick();
        drain();

        // 4. flush with a same-cycle push
        m_ready = 0; s_valid = 1;
        s_data = 32'h11; step();
        s_data = 32'h22; step();
        flush = 1; s_data = 32'h33;
        eval(1'b1);
        chk("flush_cycle_count", 32'(cnt[1]), 2);
        chk("flush_cycle_m_valid", 32'(mv[1]), 1);
        tick();
        flush = 0; s_valid = 0;
        eval(1'b1);
        chk("flush_count", 32'(cnt[1]), 0);
        chk("flush_m_valid", 32'(mv[1]), 0);
        chk("flush_m_data", md[1], RD);
        tick();
        drain();

        // 5. fall-through
        s_valid = 1; s_data = 32'h55; m_ready = 1;
        eval(1'b1);
        chk("ft_m_valid", 32'(mv[3]), 1);
        chk("ft_m_data", md[3], 32'h55);
        tick();
        s_valid = 0;
        eval(1'b1);
        chk("ft_bypass_count", 32'(cnt[3]), 0);
        tick();
        s_valid = 1; s_data = 32'h56; m_ready = 0;
        step();
        s_valid = 0;
        eval(1'b1);
        chk("ft_store_count", 32'(cnt[3]), 1);
        chk("ft_store_data", md[3], 32'h56);
        tick();
        drain();

        // randomized soak
        for (int c = 0; c < 10000; c++) begin
            rst     = ($urandom_range(0, 499) == 0);
            flush   = ($urandom_range(0, 39) == 0);
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            s_data  = $urandom;
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
